// File: rtl/uart_file_port.sv
// Host-file transfer engine: moves one file between the byte buffer
// and the PC file server over a byte UART (header, index, data).
module uart_file_port #(
  parameter int          ADDR_W    = 12,
  parameter int          LEN_W     = 12,
  parameter int          FILE_W    = 16,
  parameter int          TIMEOUT   = 2**20,
  parameter logic [7:0]  CMD_READ  = 8'h52,
  parameter logic [7:0]  CMD_WRITE = 8'h57
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [FILE_W-1:0] req_file,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [LEN_W-1:0]  req_len,
  output logic              done,
  output logic              error,
  output logic [7:0]        tx_data,
  output logic              tx_en,
  input  logic              tx_busy,
  input  logic [7:0]        rx_data,
  input  logic              rx_rdy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata
);

  localparam int NB = FILE_W / 8;
  localparam logic [7:0]  IDX_LAST = 8'(NB - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_GUARD, S_WAIT, S_IDX,
    S_RX, S_MRD, S_MSEND, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  state_t            ret_q, ret_d;
  logic              wr_q, wr_d;
  logic [FILE_W-1:0] fsh_q, fsh_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        idx_q, idx_d;
  logic [31:0]       tmo_q, tmo_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      wr_q    <= 1'b0;
      fsh_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      wr_q    <= wr_d;
      fsh_q   <= fsh_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    wr_d      = wr_q;
    fsh_d     = fsh_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    tmo_d     = '0;
    req_ready = (state_q == S_IDLE);
    done      = 1'b0;
    error     = 1'b0;
    tx_data   = 8'h00;
    tx_en     = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = 8'h00;
    mem_we    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          fsh_d   = req_file;
          addr_d  = req_base;
          cnt_d   = req_len;
          idx_d   = '0;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (!tx_busy) begin
          tx_data = wr_q ? CMD_WRITE : CMD_READ;
          tx_en   = 1'b1;
          ret_d   = S_IDX;
          state_d = S_GUARD;
        end
      end
      // UART raises busy one cycle after the strobe
      S_GUARD: state_d = S_WAIT;
      S_WAIT: begin
        if (!tx_busy) state_d = ret_q;
      end
      S_IDX: begin
        if (!tx_busy) begin
          tx_data = fsh_q[FILE_W-1 -: 8];
          tx_en   = 1'b1;
          fsh_d   = fsh_q << 8;
          idx_d   = idx_q + 8'd1;
          state_d = S_GUARD;
          if (idx_q != IDX_LAST) ret_d = S_IDX;
          else if (cnt_q == '0)  ret_d = S_DONE;
          else if (wr_q)         ret_d = S_MRD;
          else                   ret_d = S_RX;
        end
      end
      S_RX: begin
        if (rx_rdy) begin
          mem_we    = 1'b1;
          mem_wdata = rx_data;
          addr_d    = addr_q + 1'b1;
          cnt_d     = cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) state_d = S_DONE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_MRD: state_d = S_MSEND;
      S_MSEND: begin
        if (!tx_busy) begin
          tx_data = mem_rdata;
          tx_en   = 1'b1;
          addr_d  = addr_q + 1'b1;
          cnt_d   = cnt_q - 1'b1;
          ret_d   = (cnt_q == LEN_W'(1)) ? S_DONE : S_MRD;
          state_d = S_GUARD;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        done    = 1'b1;
        error   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_file_port.sv
// Directed bench for uart_file_port: UART/host/buffer models plus
// hand-computed expectations for each transfer.
module tb_uart_file_port;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_file;
  logic [11:0] req_base;
  logic [11:0] req_len;
  logic        done, error;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_busy = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata = 8'h00;

  uart_file_port #(
    .ADDR_W(12), .LEN_W(12), .FILE_W(16), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_file(req_file),
    .req_base(req_base), .req_len(req_len),
    .done(done), .error(error),
    .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_rdy(rx_rdy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 7 + 3) & 255);
  endfunction

  // Buffer model, preloaded on the first edge
  logic [7:0] mem [4096];
  bit pre_done = 0;
  always @(posedge clk) begin
    if (!pre_done) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
      pre_done <= 1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  // UART transmitter model
  logic [7:0] txq [$];
  int busy_len = 3;
  int bcnt = 0;
  int viol = 0;
  int cyc = 0;
  int rx_edge = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rx_rdy) rx_edge <= cyc + 1;
    if (tx_en) begin
      if (tx_busy) viol++;
      txq.push_back(tx_data);
      bcnt = busy_len;
    end else if (bcnt > 0) begin
      bcnt--;
    end
    tx_busy <= (bcnt > 0);
  end

  int done_cnt = 0;
  int we_cnt = 0;
  int done_cyc = 0;
  logic last_err = 1'b0;
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      last_err = error;
      done_cyc = cyc;
    end
    if (mem_we) we_cnt++;
  end

  task automatic do_req(input logic w, input logic [15:0] f,
                        input logic [11:0] b, input logic [11:0] l);
    @(negedge clk);
    check("req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = w;
    req_file  = f;
    req_base  = b;
    req_len   = l;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int k;
    k = 0;
    while (txq.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (txq.size() < n) check("tx_wait", txq.size(), n);
    repeat (busy_len + 5) @(negedge clk);
  endtask

  task automatic wait_done(input int prev);
    int k;
    k = 0;
    while (done_cnt == prev && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", done_cnt, prev + 1);
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_rdy  = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_rdy  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  int t0, d0, w0;

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0;
    req_file = '0; req_base = '0; req_len = '0;
    rx_rdy = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_tx_en", {31'd0, tx_en}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // READ 0x08A1, base 0, len 4
    t0 = txq.size(); d0 = done_cnt;
    do_req(1'b0, 16'h08A1, 12'h000, 12'd4);
    wait_tx(t0 + 3);
    send_rx(8'h11); send_rx(8'h22);
    send_rx(8'h33); send_rx(8'h44);
    wait_done(d0);
    check("rd_err", {31'd0, last_err}, 32'd0);
    check("rd_tx0", {24'd0, txq[t0]},   32'h52);
    check("rd_tx1", {24'd0, txq[t0+1]}, 32'h08);
    check("rd_tx2", {24'd0, txq[t0+2]}, 32'hA1);
    check("rd_txn", txq.size() - t0, 32'd3);
    @(negedge clk);
    check("rd_m0", {24'd0, mem[0]}, 32'h11);
    check("rd_m1", {24'd0, mem[1]}, 32'h22);
    check("rd_m2", {24'd0, mem[2]}, 32'h33);
    check("rd_m3", {24'd0, mem[3]}, 32'h44);

    // WRITE 0x0961, base 0x62A, len 10
    t0 = txq.size(); d0 = done_cnt; w0 = we_cnt;
    do_req(1'b1, 16'h0961, 12'h62A, 12'd10);
    wait_done(d0);
    check("wr_err", {31'd0, last_err}, 32'd0);
    check("wr_tx0", {24'd0, txq[t0]},   32'h57);
    check("wr_tx1", {24'd0, txq[t0+1]}, 32'h09);
    check("wr_tx2", {24'd0, txq[t0+2]}, 32'h61);
    check("wr_txn", txq.size() - t0, 32'd13);
    for (int k = 0; k < 10; k++)
      check($sformatf("wr_d%0d", k), {24'd0, txq[t0+3+k]},
            {24'd0, pat(12'h62A + k)});
    check("wr_no_we", we_cnt - w0, 32'd0);

    // READ timeout after one byte
    t0 = txq.size(); d0 = done_cnt;
    do_req(1'b0, 16'h1234, 12'h100, 12'd3);
    wait_tx(t0 + 3);
    send_rx(8'h5C);
    wait_done(d0);
    check("to_err", {31'd0, last_err}, 32'd1);
    check("to_cycles", done_cyc - rx_edge, TMO);
    check("to_mem", {24'd0, mem[12'h100]}, 32'h5C);
    check("to_mem_nx", {24'd0, mem[12'h101]}, {24'd0, pat(12'h101)});

    // READ wrapping past the top address
    t0 = txq.size(); d0 = done_cnt;
    do_req(1'b0, 16'h0042, 12'hFFE, 12'd4);
    wait_tx(t0 + 3);
    send_rx(8'hAA); send_rx(8'hBB);
    send_rx(8'hCC); send_rx(8'hDD);
    wait_done(d0);
    check("wrap_err", {31'd0, last_err}, 32'd0);
    @(negedge clk);
    check("wrap_ffe", {24'd0, mem[12'hFFE]}, 32'hAA);
    check("wrap_fff", {24'd0, mem[12'hFFF]}, 32'hBB);
    check("wrap_000", {24'd0, mem[0]}, 32'hCC);
    check("wrap_001", {24'd0, mem[1]}, 32'hDD);
    check("wrap_002", {24'd0, mem[2]}, 32'h33);

    // Reset asserted in the data phase
    t0 = txq.size(); d0 = done_cnt;
    do_req(1'b0, 16'h0007, 12'h200, 12'd4);
    wait_tx(t0 + 3);
    send_rx(8'h9E);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_ready", {31'd0, req_ready}, 32'd1);
    check("mid_done", {31'd0, done}, 32'd0);
    check("mid_mem_we", {31'd0, mem_we}, 32'd0);
    check("mid_addr", {20'd0, mem_addr}, 32'd0);
    check("mid_tx_en", {31'd0, tx_en}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (TMO + 10) @(negedge clk);
    check("mid_no_done", done_cnt, d0);
    t0 = txq.size(); d0 = done_cnt;
    do_req(1'b0, 16'h0300, 12'h300, 12'd2);
    wait_tx(t0 + 3);
    send_rx(8'h71); send_rx(8'h72);
    wait_done(d0);
    check("post_err", {31'd0, last_err}, 32'd0);
    check("post_tx1", {24'd0, txq[t0+1]}, 32'h03);
    @(negedge clk);
    check("post_m0", {24'd0, mem[12'h300]}, 32'h71);
    check("post_m1", {24'd0, mem[12'h301]}, 32'h72);

    // Slow transmitter: 50 busy cycles per byte
    busy_len = 50;
    t0 = txq.size(); d0 = done_cnt;
    do_req(1'b1, 16'h0102, 12'h010, 12'd2);
    wait_done(d0);
    check("slow_txn", txq.size() - t0, 32'd5);
    check("slow_d0", {24'd0, txq[t0+3]}, {24'd0, pat(16)});
    check("slow_d1", {24'd0, txq[t0+4]}, {24'd0, pat(17)});
    t0 = txq.size(); d0 = done_cnt;
    do_req(1'b0, 16'hBEEF, 12'h020, 12'd0);
    wait_done(d0);
    check("len0_err", {31'd0, last_err}, 32'd0);
    check("len0_txn", txq.size() - t0, 32'd3);
    check("len0_tx1", {24'd0, txq[t0+1]}, 32'hBE);
    check("len0_tx2", {24'd0, txq[t0+2]}, 32'hEF);
    check("busy_viol", viol, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
